// File: rtl/sb_pkg.sv
// Scoreboard controller types: operation codes and FSM state encoding.
`ifndef SB_DEFINES_SV
`include "defines.sv"
`endif

package sb_pkg;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_WR   = 2'd1,
      OP_RD   = 2'd2,
      OP_FL   = 2'd3
   } sb_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } sb_ctrl_state_e;

endpackage

// File: rtl/defines.sv
// Shared compile-time definitions: scoreboard capacity and the entry layout
// exchanged between issuers, the controller and the scoreboard.
`ifndef SB_DEFINES_SV
`define SB_DEFINES_SV

`define PROC_COUNT 4

typedef struct packed {
   logic [3:0]  cmd_id;
   logic [11:0] tag;
} entry_t;

`endif

// File: rtl/sb_ctrl_arb.sv
// Winner select for the scoreboard controller. Flush always wins; read vs write
// is fixed priority, or round-robin when SB_CTRL_RR_EN is defined.
`ifndef SB_DEFINES_SV
`include "defines.sv"
`endif

module sb_ctrl_arb
   import sb_pkg::*;
(
`ifdef SB_CTRL_RR_EN
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   take,
`endif
   input  logic   fl_req,
   input  logic   rd_req,
   input  logic   wr_req,
   output sb_op_e grant
);

`ifdef SB_CTRL_RR_EN
   logic pref_rd;

   // Whichever of read/write was granted last yields the next tie.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pref_rd <= 1'b1;
      end else if (take && (grant == OP_RD || grant == OP_WR)) begin
         pref_rd <= (grant == OP_WR);
      end
   end

   always_comb begin
      grant = OP_NONE;
      if (fl_req) begin
         grant = OP_FL;
      end else if (rd_req && wr_req) begin
         grant = pref_rd ? OP_RD : OP_WR;
      end else if (rd_req) begin
         grant = OP_RD;
      end else if (wr_req) begin
         grant = OP_WR;
      end
   end
`else
   always_comb begin
      grant = OP_NONE;
      if (fl_req) begin
         grant = OP_FL;
      end else if (rd_req) begin
         grant = OP_RD;
      end else if (wr_req) begin
         grant = OP_WR;
      end
   end
`endif

endmodule

// File: rtl/sb_ctrl.sv
// Scoreboard controller: serialises write/read/flush requests into one
// scoreboard operation at a time. Optional macro SB_CTRL_RR_EN (round-robin).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no operation in flight, arbitrate and latch winner
// ST_ISSUE | one-cycle command strobe for the latched op
// ST_WAIT  | entry held stable, waiting for scoreboard ack
// ST_RESP  | one-cycle done pulse to the winning requester
`ifndef SB_DEFINES_SV
`include "defines.sv"
`endif

module sb_ctrl
   import sb_pkg::*;
#(
   parameter int N_ENTRIES = `PROC_COUNT,
   parameter int ID_W      = $clog2(N_ENTRIES)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_wr_req,
   input  entry_t          i_wr_entry,
   output logic            o_wr_done,
   input  logic            i_rd_req,
   input  entry_t          i_rd_entry,
   output logic            o_rd_done,
   output logic            o_rd_exists,
   output logic [ID_W-1:0] o_rd_id,
   input  logic            i_fl_req,
   input  entry_t          i_fl_entry,
   output logic            o_fl_done,
   output logic            o_fl_hit,
   output entry_t          o_sb_entry,
   output logic            o_sb_write,
   output logic            o_sb_read,
   output logic            o_sb_flush,
   input  logic            i_sb_ack,
   input  logic            i_sb_exists,
   input  logic [ID_W-1:0] i_sb_id,
   output logic [ID_W:0]   o_count,
   output logic            o_full,
   output logic            o_busy
);

   localparam logic [ID_W:0] FULL_CNT = (ID_W + 1)'(N_ENTRIES);

   sb_ctrl_state_e  state_q, state_d;
   sb_op_e          op_q, grant;
   entry_t          entry_q, sel_entry;
   logic            exists_q;
   logic [ID_W-1:0] id_q;
   logic [ID_W:0]   count_q;
   logic            full, take, ack_take;

   assign full     = (count_q == FULL_CNT);
   assign take     = (state_q == ST_IDLE) && (grant != OP_NONE);
   assign ack_take = (state_q == ST_WAIT) && i_sb_ack;

   sb_ctrl_arb u_arb (
`ifdef SB_CTRL_RR_EN
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .take   (take),
`endif
      .fl_req (i_fl_req),
      .rd_req (i_rd_req),
      .wr_req (i_wr_req && !full),
      .grant  (grant)
   );

   always_comb begin
      sel_entry = '0;
      case (grant)
         OP_FL:   sel_entry = i_fl_entry;
         OP_RD:   sel_entry = i_rd_entry;
         OP_WR:   sel_entry = i_wr_entry;
         default: sel_entry = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_NONE;
         entry_q  <= '0;
         exists_q <= 1'b0;
         id_q     <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            op_q    <= grant;
            entry_q <= sel_entry;
         end
         if (ack_take) begin
            exists_q <= i_sb_exists;
            id_q     <= i_sb_id;
            // Saturating guards keep the count sane even if the scoreboard misbehaves.
            if (op_q == OP_WR && !full) begin
               count_q <= count_q + 1'b1;
            end else if (op_q == OP_FL && i_sb_exists && count_q != '0) begin
               count_q <= count_q - 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      o_sb_write  = 1'b0;
      o_sb_read   = 1'b0;
      o_sb_flush  = 1'b0;
      o_wr_done   = 1'b0;
      o_rd_done   = 1'b0;
      o_fl_done   = 1'b0;
      o_rd_exists = 1'b0;
      o_rd_id     = '0;
      o_fl_hit    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant != OP_NONE) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            o_sb_write = (op_q == OP_WR);
            o_sb_read  = (op_q == OP_RD);
            o_sb_flush = (op_q == OP_FL);
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_sb_ack) state_d = ST_RESP;
         end
         ST_RESP: begin
            o_wr_done = (op_q == OP_WR);
            o_rd_done = (op_q == OP_RD);
            o_fl_done = (op_q == OP_FL);
            if (op_q == OP_RD) begin
               o_rd_exists = exists_q;
               o_rd_id     = id_q;
            end
            o_fl_hit = (op_q == OP_FL) && exists_q;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_sb_entry = entry_q;
   assign o_count    = count_q;
   assign o_full     = full;
   assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sb_ctrl.sv
// Scoreboard-style bench for sb_ctrl: a reference set model predicts every
// scoreboard answer and every done response; monitors compare as the DUT responds.
module tb_sb_ctrl;
   import sb_pkg::*;

   localparam int N  = 4;
   localparam int IW = 2;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_wr_req, i_rd_req, i_fl_req;
   entry_t        i_wr_entry, i_rd_entry, i_fl_entry;
   logic          o_wr_done, o_rd_done, o_rd_exists, o_fl_done, o_fl_hit;
   logic [IW-1:0] o_rd_id;
   entry_t        o_sb_entry;
   logic          o_sb_write, o_sb_read, o_sb_flush;
   logic          i_sb_ack, i_sb_exists;
   logic [IW-1:0] i_sb_id;
   logic [IW:0]   o_count;
   logic          o_full, o_busy;

   sb_ctrl #(.N_ENTRIES(N), .ID_W(IW)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_wr_req(i_wr_req), .i_wr_entry(i_wr_entry), .o_wr_done(o_wr_done),
      .i_rd_req(i_rd_req), .i_rd_entry(i_rd_entry), .o_rd_done(o_rd_done),
      .o_rd_exists(o_rd_exists), .o_rd_id(o_rd_id),
      .i_fl_req(i_fl_req), .i_fl_entry(i_fl_entry), .o_fl_done(o_fl_done), .o_fl_hit(o_fl_hit),
      .o_sb_entry(o_sb_entry), .o_sb_write(o_sb_write), .o_sb_read(o_sb_read), .o_sb_flush(o_sb_flush),
      .i_sb_ack(i_sb_ack), .i_sb_exists(i_sb_exists), .i_sb_id(i_sb_id),
      .o_count(o_count), .o_full(o_full), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc++;

   typedef struct { sb_op_e op; entry_t e; logic ex; logic [IW-1:0] id; } resp_t;
   typedef struct { logic ex; logic [IW-1:0] id; logic [IW:0] cnt; } exp_t;

   resp_t         resp_q[$];
   exp_t          exp_wr[$], exp_rd[$], exp_fl[$];
   entry_t        m_ent[$];
   logic [IW-1:0] m_id[$];
   sb_op_e        grant_log[$];

   int checks = 0, errors = 0;
   int wr_strobes = 0, last_rd_done_cyc = 0;
   int ack_lat = 1, spur_cnt = 0;
   bit lat_rand = 0, abort = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void unexpected(string nm);
      checks++;
      errors++;
      $display("FAIL %s: event with nothing expected (cycle %0d)", nm, cyc);
   endfunction

   function automatic entry_t mk(int c);
      entry_t e;
      e.cmd_id = 4'(c);
      e.tag    = 12'(c * 37 + 5);
      return e;
   endfunction

   function automatic bit present(entry_t e);
      foreach (m_ent[i]) if (m_ent[i] == e) return 1'b1;
      return 1'b0;
   endfunction

   // Reference scoreboard: a set of entries, each holding the lowest free proc id.
   function automatic void plan(sb_op_e op, entry_t e);
      resp_t r;
      exp_t x;
      int hit;
      logic [IW-1:0] nid;
      hit = -1;
      foreach (m_ent[i]) if (m_ent[i] == e) hit = i;
      r.op = op; r.e = e; r.ex = 1'b0; r.id = '0;
      x.ex = 1'b0; x.id = '0;
      nid = '0;
      if (op == OP_WR) begin
         for (int k = N - 1; k >= 0; k--) begin
            bit used;
            used = 1'b0;
            foreach (m_id[j]) if (m_id[j] == IW'(k)) used = 1'b1;
            if (!used) nid = IW'(k);
         end
         m_ent.push_back(e);
         m_id.push_back(nid);
         r.id = nid;
      end else if (hit >= 0) begin
         r.ex = 1'b1; r.id = m_id[hit];
         x.ex = 1'b1; x.id = m_id[hit];
         if (op == OP_FL) begin
            m_ent.delete(hit);
            m_id.delete(hit);
         end
      end
      x.cnt = (IW + 1)'(m_ent.size());
      resp_q.push_back(r);
      if (op == OP_WR) exp_wr.push_back(x);
      else if (op == OP_RD) exp_rd.push_back(x);
      else exp_fl.push_back(x);
   endfunction

   task automatic drive(sb_op_e op, entry_t e);
      bit done;
      done = 1'b0;
      case (op)
         OP_WR:   begin i_wr_entry = e; i_wr_req = 1'b1; end
         OP_RD:   begin i_rd_entry = e; i_rd_req = 1'b1; end
         default: begin i_fl_entry = e; i_fl_req = 1'b1; end
      endcase
      for (int k = 0; k < 300 && !done && !abort; k++) begin
         @(negedge i_clk);
         case (op)
            OP_WR:   done = o_wr_done;
            OP_RD:   done = o_rd_done;
            default: done = o_fl_done;
         endcase
      end
      if (done) begin
         @(posedge i_clk);
         #1;
      end
      if (!abort) chk($sformatf("done_seen_%s", op.name()), done, 1);
      case (op)
         OP_WR:   i_wr_req = 1'b0;
         OP_RD:   i_rd_req = 1'b0;
         default: i_fl_req = 1'b0;
      endcase
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      m_ent.delete(); m_id.delete(); resp_q.delete();
      exp_wr.delete(); exp_rd.delete(); exp_fl.delete();
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
   endtask

   // Scoreboard responder: answers each strobe from the planned response queue.
   initial begin
      int pend;
      int seen_spur;
      resp_t cur;
      sb_op_e sop;
      pend = 0;
      seen_spur = 0;
      i_sb_ack = 1'b0; i_sb_exists = 1'b0; i_sb_id = '0;
      forever begin
         @(negedge i_clk);
         i_sb_ack = 1'b0; i_sb_exists = 1'b0; i_sb_id = '0;
         if (i_rst) begin
            pend = 0;
            seen_spur = spur_cnt;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               chk("sb_entry_stable", o_sb_entry, cur.e);
               i_sb_ack = 1'b1; i_sb_exists = cur.ex; i_sb_id = cur.id;
            end
         end else if (o_sb_write || o_sb_read || o_sb_flush) begin
            sop = o_sb_flush ? OP_FL : (o_sb_read ? OP_RD : OP_WR);
            if (resp_q.size() == 0) begin
               unexpected("sb_strobe");
            end else begin
               cur = resp_q.pop_front();
               chk("strobe_order", sop, cur.op);
               chk("strobe_entry", o_sb_entry, cur.e);
               pend = lat_rand ? int'($urandom_range(1, 4)) : ack_lat;
            end
         end else if (spur_cnt != seen_spur) begin
            seen_spur = spur_cnt;
            i_sb_ack = 1'b1; i_sb_exists = 1'b1; i_sb_id = IW'($urandom_range(0, N - 1));
         end
      end
   end

   // Strobe monitor: one-hot and grant order log.
   initial begin
      int nst;
      forever begin
         @(negedge i_clk);
         nst = int'(o_sb_write) + int'(o_sb_read) + int'(o_sb_flush);
         if (nst != 0 && !i_rst) begin
            chk("strobe_onehot", nst, 1);
            if (o_sb_write) wr_strobes++;
            grant_log.push_back(o_sb_flush ? OP_FL : (o_sb_read ? OP_RD : OP_WR));
         end
      end
   end

   // Response monitor.
   initial begin
      exp_t x;
      forever begin
         @(negedge i_clk);
         if (o_wr_done) begin
            if (exp_wr.size() == 0) unexpected("wr_done");
            else begin
               x = exp_wr.pop_front();
               chk("wr_count", o_count, x.cnt);
            end
         end
         if (o_rd_done) begin
            last_rd_done_cyc = cyc;
            if (exp_rd.size() == 0) unexpected("rd_done");
            else begin
               x = exp_rd.pop_front();
               chk("rd_exists", o_rd_exists, x.ex);
               chk("rd_id", o_rd_id, x.id);
               chk("rd_count", o_count, x.cnt);
            end
         end
         if (o_fl_done) begin
            if (exp_fl.size() == 0) unexpected("fl_done");
            else begin
               x = exp_fl.pop_front();
               chk("fl_hit", o_fl_hit, x.ex);
               chk("fl_count", o_count, x.cnt);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench time limit reached (cycle %0d)", cyc);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, g0, w0, ri, wi, op_sel, c;
      bit seen;
      sb_op_e seq[$];
      sb_op_e op;

      // Reset with a request pending: reset must dominate.
      i_rst = 1'b1;
      i_wr_req = 1'b0; i_rd_req = 1'b0; i_fl_req = 1'b1;
      i_wr_entry = '0; i_rd_entry = '0; i_fl_entry = mk(1);
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_count", o_count, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_full", o_full, 0);
      chk("rst_sb_entry", o_sb_entry, 0);
      chk("rst_strobes", {o_sb_write, o_sb_read, o_sb_flush}, 0);
      chk("rst_dones", {o_wr_done, o_rd_done, o_fl_done}, 0);
      chk("rst_results", {o_rd_exists, o_fl_hit, o_rd_id}, 0);
      i_fl_req = 1'b0;
      @(posedge i_clk);
      #1 i_rst = 1'b0;

      // Fill to capacity, then a fifth write must stall.
      ack_lat = 1;
      for (int i = 0; i < 4; i++) begin
         plan(OP_WR, mk(i));
         drive(OP_WR, mk(i));
      end
      chk("fill_count", o_count, 4);
      chk("fill_full", o_full, 1);
      w0 = wr_strobes;
      fork
         drive(OP_WR, mk(4));
      join_none
      repeat (15) @(negedge i_clk);
      chk("stall_no_write", wr_strobes, w0);
      chk("stall_busy", o_busy, 0);
      chk("stall_count", o_count, 4);

      // Flush hit frees a slot; the held write is then served.
      plan(OP_FL, mk(2));
      plan(OP_WR, mk(4));
      ack_lat = 2;
      drive(OP_FL, mk(2));
      wait fork;
      chk("refill_count", o_count, 4);
      chk("refill_full", o_full, 1);

      // Single read hit with ack two cycles after the strobe: done lands in
      // the fifth cycle counting the request cycle (IDLE,ISSUE,WAIT,WAIT,RESP).
      @(posedge i_clk);
      #1;
      t0 = cyc;
      plan(OP_RD, mk(3));
      drive(OP_RD, mk(3));
      chk("rd_latency", last_rd_done_cyc - t0, 4);

      // All three requests in the same cycle.
      ack_lat = 1;
      g0 = grant_log.size();
      plan(OP_FL, mk(0));
      plan(OP_RD, mk(0));
      plan(OP_WR, mk(5));
      fork
         drive(OP_FL, mk(0));
         drive(OP_RD, mk(0));
         drive(OP_WR, mk(5));
      join
      chk("tri_grants", grant_log.size() - g0, 3);
      if (grant_log.size() - g0 == 3) begin
         chk("tri_first", grant_log[g0], OP_FL);
         chk("tri_second", grant_log[g0 + 1], OP_RD);
         chk("tri_third", grant_log[g0 + 2], OP_WR);
      end

      // Read and write held continuously after reset.
      @(posedge i_clk);
      #1;
      do_reset();
`ifdef SB_CTRL_RR_EN
      seq = '{OP_RD, OP_WR, OP_RD, OP_WR, OP_RD, OP_WR, OP_RD};
`else
      seq = '{OP_RD, OP_RD, OP_RD, OP_RD, OP_WR, OP_WR, OP_WR};
`endif
      ri = 0; wi = 0;
      foreach (seq[i]) begin
         if (seq[i] == OP_RD) begin plan(OP_RD, mk(9 + ri)); ri++; end
         else begin plan(OP_WR, mk(wi)); wi++; end
      end
      g0 = grant_log.size();
      fork
         for (int i = 0; i < 4; i++) drive(OP_RD, mk(9 + i));
         for (int i = 0; i < 3; i++) drive(OP_WR, mk(i));
      join
      chk("held_grants", grant_log.size() - g0, 7);
      if (grant_log.size() - g0 == 7)
         foreach (seq[i]) chk($sformatf("held_grant_%0d", i), grant_log[g0 + i], seq[i]);

      // Reset while waiting for the scoreboard aborts the read silently.
      ack_lat = 4;
      @(posedge i_clk);
      #1;
      plan(OP_RD, mk(0));
      fork
         drive(OP_RD, mk(0));
      join_none
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge i_clk);
         seen = o_sb_read;
      end
      chk("abort_strobe_seen", seen, 1);
      @(posedge i_clk);
      #1;
      abort = 1'b1;
      i_rst = 1'b1;
      m_ent.delete(); m_id.delete(); resp_q.delete();
      exp_wr.delete(); exp_rd.delete(); exp_fl.delete();
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      chk("abort_busy", o_busy, 0);
      chk("abort_count", o_count, 0);
      chk("abort_no_done", o_rd_done, 0);
      wait fork;
      abort = 1'b0;
      repeat (6) @(negedge i_clk);

      // Randomised sequential traffic with random ack latency and stray acks.
      lat_rand = 1'b1;
      for (int n = 0; n < 80; n++) begin
         @(posedge i_clk);
         #1;
         op_sel = int'($urandom_range(0, 2));
         c = int'($urandom_range(0, 7));
         op = (op_sel == 0) ? OP_WR : ((op_sel == 1) ? OP_RD : OP_FL);
         if (op == OP_WR && (present(mk(c)) || m_ent.size() == N)) op = OP_RD;
         plan(op, mk(c));
         drive(op, mk(c));
         if ($urandom_range(0, 3) == 0) begin
            spur_cnt++;
            repeat (3) @(negedge i_clk);
            chk("stray_ack_count", o_count, m_ent.size());
            chk("stray_ack_busy", o_busy, 0);
         end
      end

      repeat (5) @(negedge i_clk);
      chk("resp_q_drained", resp_q.size(), 0);
      chk("exp_drained", exp_wr.size() + exp_rd.size() + exp_fl.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
